// File: rtl/ysyx_24100029_clint_mtimer_if.sv
// Request/response bus shared by the CLINT-window peripherals.
//   addr   : byte address (only [11:0] decoded by the timer)
//   opcode : 0 idle, 1 read, 2 write, 3 reserved (idle)
//   wdata  : write data, wstrb : byte enables
//   rdata  : read data, valid while resp is high
//   resp   : one-cycle response pulse, one per accepted request
interface ysyx_24100029_clint_mtimer_if;
   logic [31:0] addr;
   logic [1:0]  opcode;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        resp;

   modport master (output addr, opcode, wdata, wstrb, input rdata, resp);
   modport slave  (input addr, opcode, wdata, wstrb, output rdata, resp);
endinterface

// File: rtl/ysyx_24100029_clint_mtimer.sv
// Core-local interruptor: 64-bit prescaled mtime, per-hart mtimecmp and
// msip, registered mtip, single-cycle registered read response.
//   clock, reset : rising-edge clock, async active-high reset
//   bus          : request/response bus (slave side)
//   mtip         : per-hart timer interrupt pending (registered compare)
//   msip         : per-hart software interrupt pending
module ysyx_24100029_clint_mtimer #(
   parameter int HART_NUM = 1,
   parameter int PRESCALE = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   ysyx_24100029_clint_mtimer_if.slave bus,
   output logic [HART_NUM-1:0]       mtip,
   output logic [HART_NUM-1:0]       msip
);

   localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

   logic [63:0] mtime_q, mtime_d;
   logic [15:0] pre_q, pre_d;
   logic [31:0] hi_shadow_q;
   logic [63:0] mtimecmp_q [HART_NUM];
   logic [63:0] mtimecmp_d [HART_NUM];
   logic [HART_NUM-1:0] msip_q, msip_d;
   logic [HART_NUM-1:0] mtip_q;
   logic [31:0] rdata_q;
   logic        resp_q;

   logic [11:0] off;
   logic        rd_en, wr_en, word_ok, sel_lo, sel_hi;
   logic [HART_NUM-1:0] cmp_sel, msip_sel;
   logic [31:0] rd_val;
   logic        unused_addr;

   function automatic logic [31:0] merge32(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [3:0]  st);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   assign off         = bus.addr[11:0];
   assign unused_addr = ^bus.addr[31:12];
   assign rd_en       = (bus.opcode == 2'd1);
   assign wr_en       = (bus.opcode == 2'd2);
   assign word_ok     = (off[1:0] == 2'b00);
   assign sel_lo      = (off == 12'h000);
   assign sel_hi      = (off == 12'h004);

   always_comb begin
      for (int h = 0; h < HART_NUM; h++) begin
         cmp_sel[h]  = word_ok && (off[11:3] == 9'(h + 1));
         msip_sel[h] = word_ok && (off[11:4] == 8'h10) && (off[3:2] == 2'(h));
      end
   end

   // The high word reads from the shadow so a low/high read pair is coherent.
   always_comb begin
      rd_val = '0;
      if (sel_lo) rd_val = mtime_q[31:0];
      if (sel_hi) rd_val = hi_shadow_q;
      for (int h = 0; h < HART_NUM; h++) begin
         if (cmp_sel[h])  rd_val = off[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
         if (msip_sel[h]) rd_val = {31'b0, msip_q[h]};
      end
   end

   // A write to either mtime half suppresses the increment and restarts the prescaler phase.
   always_comb begin
      if (pre_q == PRE_MAX) begin
         mtime_d = mtime_q + 64'd1;
         pre_d   = '0;
      end else begin
         mtime_d = mtime_q;
         pre_d   = pre_q + 16'd1;
      end
      if (wr_en && sel_lo) begin
         mtime_d = {mtime_q[63:32], merge32(mtime_q[31:0], bus.wdata, bus.wstrb)};
         pre_d   = '0;
      end
      if (wr_en && sel_hi) begin
         mtime_d = {merge32(mtime_q[63:32], bus.wdata, bus.wstrb), mtime_q[31:0]};
         pre_d   = '0;
      end
   end

   always_comb begin
      for (int h = 0; h < HART_NUM; h++) begin
         mtimecmp_d[h] = mtimecmp_q[h];
         msip_d[h]     = msip_q[h];
         if (wr_en && cmp_sel[h]) begin
            if (off[2])
               mtimecmp_d[h][63:32] = merge32(mtimecmp_q[h][63:32], bus.wdata, bus.wstrb);
            else
               mtimecmp_d[h][31:0]  = merge32(mtimecmp_q[h][31:0], bus.wdata, bus.wstrb);
         end
         if (wr_en && msip_sel[h] && bus.wstrb[0]) msip_d[h] = bus.wdata[0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mtime_q     <= '0;
         pre_q       <= '0;
         hi_shadow_q <= '0;
         msip_q      <= '0;
         mtip_q      <= '0;
         rdata_q     <= '0;
         resp_q      <= 1'b0;
         for (int h = 0; h < HART_NUM; h++) mtimecmp_q[h] <= '1;
      end else begin
         mtime_q <= mtime_d;
         pre_q   <= pre_d;
         msip_q  <= msip_d;
         resp_q  <= rd_en | wr_en;
         rdata_q <= rd_en ? rd_val : 32'd0;
         if (rd_en && sel_lo) hi_shadow_q <= mtime_q[63:32];
         for (int h = 0; h < HART_NUM; h++) begin
            mtimecmp_q[h] <= mtimecmp_d[h];
            mtip_q[h]     <= (mtime_q >= mtimecmp_q[h]);
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.resp  = resp_q;
   assign mtip      = mtip_q;
   assign msip      = msip_q;

endmodule

// File: tb/tb_ysyx_24100029_clint_mtimer.sv
module tb_ysyx_24100029_clint_mtimer;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ysyx_24100029_clint_mtimer_if bus_a ();
   ysyx_24100029_clint_mtimer_if bus_b ();

   logic [1:0] mtip_a, msip_a;
   logic [0:0] mtip_b, msip_b;

   ysyx_24100029_clint_mtimer #(.HART_NUM(2), .PRESCALE(1)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a), .mtip(mtip_a), .msip(msip_a));

   ysyx_24100029_clint_mtimer #(.HART_NUM(1), .PRESCALE(4)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b), .mtip(mtip_b), .msip(msip_b));

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   localparam logic [1:0] RD = 2'd1;
   localparam logic [1:0] WR = 2'd2;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every response pops the oldest expected read data.
   always @(negedge clock) begin
      if (bus_a.resp === 1'b1) begin
         if (qa.size() == 0) begin
            compared++; mismatched++;
            $error("FAIL resp_a_unexpected observed=1 expected=0");
         end else check("rdata_a", {32'd0, bus_a.rdata}, {32'd0, qa.pop_front()});
      end
      if (bus_b.resp === 1'b1) begin
         if (qb.size() == 0) begin
            compared++; mismatched++;
            $error("FAIL resp_b_unexpected observed=1 expected=0");
         end else check("rdata_b", {32'd0, bus_b.rdata}, {32'd0, qb.pop_front()});
      end
   end

   // Starts and ends on a falling edge; consecutive calls are back-to-back requests.
   task automatic xfer(input int b, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input logic [31:0] exp);
      if (b == 0) begin
         qa.push_back(exp);
         bus_a.opcode = op; bus_a.addr = a; bus_a.wdata = wd; bus_a.wstrb = st;
      end else begin
         qb.push_back(exp);
         bus_b.opcode = op; bus_b.addr = a; bus_b.wdata = wd; bus_b.wstrb = st;
      end
      @(negedge clock);
      if (b == 0) begin
         check("resp_a_pulse", {63'd0, bus_a.resp}, 64'd1);
         bus_a.opcode = 2'd0;
      end else begin
         check("resp_b_pulse", {63'd0, bus_b.resp}, 64'd1);
         bus_b.opcode = 2'd0;
      end
   endtask

   initial begin
      reset = 1'b1;
      bus_a.opcode = 2'd0; bus_a.addr = '0; bus_a.wdata = '0; bus_a.wstrb = '0;
      bus_b.opcode = 2'd0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.wstrb = '0;
      repeat (2) @(negedge clock);
      check("rst_resp",  {63'd0, bus_a.resp}, 64'd0);
      check("rst_rdata", {32'd0, bus_a.rdata}, 64'd0);
      check("rst_mtip",  {62'd0, mtip_a}, 64'd0);
      check("rst_msip",  {62'd0, msip_a}, 64'd0);
      check("rst_mtip_b", {63'd0, mtip_b}, 64'd0);
      reset = 1'b0;

      // free run
      repeat (100) @(negedge clock);
      xfer(0, RD, 32'h000, 0, 0, 32'd100);
      check("freerun_mtip", {62'd0, mtip_a}, 64'd0);
      @(negedge clock);
      check("resp_single_cycle", {63'd0, bus_a.resp}, 64'd0);
      check("rdata_idle_zero", {32'd0, bus_a.rdata}, 64'd0);
      xfer(0, RD, 32'h008, 0, 0, 32'hFFFF_FFFF);
      xfer(0, RD, 32'h00C, 0, 0, 32'hFFFF_FFFF);

      // carry into high word and snapshot shadow
      xfer(0, WR, 32'h000, 32'hFFFF_FFFE, 4'hF, 32'd0);
      xfer(0, WR, 32'h004, 32'h0000_0001, 4'hF, 32'd0);
      repeat (4) @(negedge clock);
      xfer(0, RD, 32'h000, 0, 0, 32'h2);
      xfer(0, RD, 32'h004, 0, 0, 32'h2);
      xfer(0, WR, 32'h004, 32'h7, 4'hF, 32'd0);
      xfer(0, RD, 32'h004, 0, 0, 32'h2);
      xfer(0, RD, 32'h000, 0, 0, 32'h5);
      xfer(0, RD, 32'h004, 0, 0, 32'h7);

      // 64-bit wrap
      xfer(0, WR, 32'h000, 32'hFFFF_FFFF, 4'hF, 32'd0);
      xfer(0, WR, 32'h004, 32'hFFFF_FFFF, 4'hF, 32'd0);
      xfer(0, RD, 32'h000, 0, 0, 32'hFFFF_FFFF);
      xfer(0, RD, 32'h000, 0, 0, 32'h0);
      xfer(0, RD, 32'h004, 0, 0, 32'h0);

      // compare for hart 1: mtime=40 after the second write, cmp=50
      xfer(0, WR, 32'h004, 32'd0, 4'hF, 32'd0);
      xfer(0, WR, 32'h000, 32'd40, 4'hF, 32'd0);
      xfer(0, WR, 32'h010, 32'd50, 4'hF, 32'd0);
      xfer(0, WR, 32'h014, 32'd0, 4'hF, 32'd0);
      for (int k = 4; k <= 13; k++) begin
         @(negedge clock);
         check($sformatf("mtip1_k%0d", k), {63'd0, mtip_a[1]}, (k >= 12) ? 64'd1 : 64'd0);
         check($sformatf("mtip0_k%0d", k), {63'd0, mtip_a[0]}, 64'd0);
      end
      xfer(0, WR, 32'h014, 32'd1, 4'hF, 32'd0);
      check("mtip1_before_clear", {63'd0, mtip_a[1]}, 64'd1);
      @(negedge clock);
      check("mtip1_cleared", {63'd0, mtip_a[1]}, 64'd0);

      // msip and byte strobes
      xfer(0, WR, 32'h104, 32'h1, 4'h1, 32'd0);
      check("msip_set1", {62'd0, msip_a}, 64'h2);
      xfer(0, WR, 32'h104, 32'h1, 4'h0, 32'd0);
      check("msip_nostrb", {62'd0, msip_a}, 64'h2);
      xfer(0, RD, 32'h104, 0, 0, 32'h1);
      xfer(0, WR, 32'h104, 32'h0, 4'h1, 32'd0);
      check("msip_clr1", {62'd0, msip_a}, 64'h0);
      xfer(0, WR, 32'h100, 32'hFFFF_FFFF, 4'hF, 32'd0);
      check("msip_set0", {62'd0, msip_a}, 64'h1);
      xfer(0, RD, 32'h100, 0, 0, 32'h1);
      xfer(0, WR, 32'h008, 32'hAABB_CCDD, 4'h5, 32'd0);
      xfer(0, RD, 32'h008, 0, 0, 32'hFFBB_FFDD);
      xfer(0, RD, 32'h00C, 0, 0, 32'hFFFF_FFFF);
      xfer(0, WR, 32'h018, 32'h0, 4'hF, 32'd0);
      xfer(0, RD, 32'h018, 0, 0, 32'h0);
      xfer(0, RD, 32'h01C, 0, 0, 32'h0);
      xfer(0, RD, 32'h108, 0, 0, 32'h0);

      // reserved opcode behaves as idle
      bus_a.opcode = 2'd3; bus_a.addr = 32'h100; bus_a.wdata = 32'h0; bus_a.wstrb = 4'hF;
      @(negedge clock);
      bus_a.opcode = 2'd0;
      check("opcode3_no_resp", {63'd0, bus_a.resp}, 64'd0);
      check("opcode3_no_write", {62'd0, msip_a}, 64'h1);

      // unmapped read, then reset during the response
      xfer(0, WR, 32'h00C, 32'h0, 4'hF, 32'd0);
      xfer(0, WR, 32'h008, 32'h0, 4'hF, 32'd0);
      xfer(0, RD, 32'h200, 0, 0, 32'h0);
      #2;
      check("abort_pre_mtip", {62'd0, mtip_a}, 64'h1);
      check("abort_pre_msip", {62'd0, msip_a}, 64'h1);
      check("abort_pre_resp", {63'd0, bus_a.resp}, 64'd1);
      reset = 1'b1;
      #1;
      check("abort_resp",  {63'd0, bus_a.resp}, 64'd0);
      check("abort_rdata", {32'd0, bus_a.rdata}, 64'd0);
      check("abort_mtip",  {62'd0, mtip_a}, 64'd0);
      check("abort_msip",  {62'd0, msip_a}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // prescaler of 4: write restarts the phase
      xfer(1, WR, 32'h000, 32'd100, 4'hF, 32'd0);
      for (int k = 1; k <= 9; k++)
         xfer(1, RD, 32'h000, 0, 0, (k <= 4) ? 32'd100 : (k <= 8) ? 32'd101 : 32'd102);
      @(negedge clock);

      check("queue_a_drained", 64'(qa.size()), 64'd0);
      check("queue_b_drained", 64'(qb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ysyx_24100029_clint_mtimer.md
# ysyx_24100029_clint_mtimer

Parametrised core-local interruptor for the NPC SoC. Holds a 64-bit free-running `mtime` with a programmable prescaler, a 64-bit `mtimecmp` per hart and a software-interrupt bit per hart, and drives per-hart `mtip`/`msip` lines to the CSR units. It sits on the same simple memory-side request bus as the other CLINT-window peripherals and returns read data with a registered one-cycle response.

## Interface
- `HART_NUM`, default 1: number of harts, legal range 1..4.
- `PRESCALE`, default 1: `mtime` increments once every `PRESCALE` clocks, legal range 1..65535.
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `addr`, input, 32: byte address; only `addr[11:0]` is decoded.
- `opcode`, input, 2: 0 = idle, 1 = read, 2 = write, 3 = reserved (treated as idle).
- `wdata`, input, 32: write data.
- `wstrb`, input, 4: byte enables for writes; bit i enables `wdata[8i+7:8i]`.
- `rdata`, output, 32: read data, valid while `resp`=1.
- `resp`, output, 1: one-cycle response pulse.
- `mtip`, output, HART_NUM: timer interrupt pending, one bit per hart.
- `msip`, output, HART_NUM: software interrupt pending, one bit per hart.

## Operation
- Address map (offset = `addr[11:0]`):
  - 0x000 `mtime[31:0]`, 0x004 `mtime[63:32]`.
  - 0x008+8h `mtimecmp[h][31:0]`, 0x00C+8h `mtimecmp[h][63:32]`, h < HART_NUM.
  - 0x100+4h `msip[h]` (bit 0; bits 31:1 read 0, ignored on write).
  - Any other offset, or h ≥ HART_NUM: reads return 0, writes ignored, `resp` still pulses.
- Prescaler: counter `pre` runs 0..PRESCALE-1, wraps to 0; `mtime` increments in the cycle `pre` == PRESCALE-1. With PRESCALE=1, `mtime` increments every cycle.
- `mtime` is a single 64-bit add; carry from bit 31 to 32 is automatic; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write to either `mtime` half: byte-masked merge into that half; the written value wins over the increment in the same cycle (no increment that cycle); the other half is unchanged; `pre` is reset to 0.
- Read snapshot: a read of 0x000 returns `mtime[31:0]` and copies `mtime[63:32]` into a `hi_shadow` register. A read of 0x004 returns `hi_shadow`, not the live high word. `hi_shadow` is not affected by `mtime` writes.
- `mtimecmp` halves and `msip` use byte-masked writes; writes with `wstrb`=0 change nothing.
- `mtip[h]` is registered: `mtip[h]` <= (`mtime` ≥ `mtimecmp[h]`), 64-bit unsigned compare of the current register values. It is level-sensitive, and clears once `mtimecmp` is raised above `mtime`.
- `msip[h]` is driven directly from its register bit.

## Timing
- Reset values: `mtime`=0, `pre`=0, every `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `msip`=0, `mtip`=0, `hi_shadow`=0, `rdata`=0, `resp`=0.
- Request sampled on edge N (opcode 1/2); `resp`=1 during cycle N+1; `rdata` is valid in N+1 and is 0 for writes. `rdata` returns to 0 when `resp` is low.
- Back-to-back requests are accepted every cycle, with no stall. A read returns register contents as of edge N, before any same-edge write or increment.
- Write effects are visible to a read issued in the next cycle.
- `mtip` lags `mtime`/`mtimecmp` by one cycle: if the registers satisfy ≥ after edge N, `mtip` rises after edge N+1.
- Reset asserted mid-transaction: all outputs drop to their reset values immediately, and any pending `resp` is lost.

## Test plan
- Reset/free-run: PRESCALE=1, release reset, wait 100 cycles, read 0x000 -> `rdata` ≈ 100 (exact count per bench alignment), `resp` is a single-cycle pulse, `mtip`=0.
- Carry and snapshot: write 0x000=0xFFFF_FFFE, 0x004=0x0000_0001; read 0x000 after 4 cycles -> low word small (e.g. 0x2), then read 0x004 -> 0x0000_0002. Write 0x004=0x7; read 0x004 -> still 0x2 (shadow).
- Compare: HART_NUM=2; write `mtimecmp[1]`=50 (0x010=50, 0x014=0) -> `mtip[1]` rises exactly one cycle after `mtime` reaches 50, `mtip[0]` stays 0; write 0x014=1 -> `mtip[1]` clears the next cycle.
- Prescaler: PRESCALE=4 -> `mtime` increments once every 4 cycles; a write to `mtime` resets the phase, so the next increment occurs 4 cycles after the write.
- Byte strobes/msip: write 0x104 with wdata=0x1 and wstrb=0x1 -> `msip[1]`=1; write again with wstrb=0x0 -> unchanged; write wdata=0 and wstrb=0x1 -> 0.
- Unmapped / reset abort: read 0x200 -> `rdata`=0 with `resp`=1; assert `reset` in the response cycle -> `resp`, `rdata`, `mtip`, `msip` go to 0 asynchronously.
